// File: rtl/sap_fetch_sequencer.sv
// sap_fetch_sequencer: instruction fetch/decode sequencer paired with the SAP program counter.
// Fetches opcode and operand bytes at the current PC and drives the PC's count/branch
// requests. It issues one execute strobe for each non-branch instruction. The sequencer
// only advances on cycles where SLOW_CLOCK_STRB is high, which keeps it in step with the PC.
module sap_fetch_sequencer #(
  parameter logic [3:0] OP_JMP = 4'h6,
  parameter logic [3:0] OP_JZ  = 4'h7,
  parameter logic [3:0] OP_JC  = 4'h8,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       CLK,
  input  logic       ACLR,
  input  logic       SLOW_CLOCK_STRB,
  input  logic [7:0] MEM_DATA,
  input  logic       ZERO_FLAG,
  input  logic       CARRY_FLAG,
  output logic       PC_COUNT,
  output logic       BRANCH,
  output logic [7:0] BRANCH_ADDRESS,
  output logic [7:0] IR,
  output logic       EXEC_STRB,
  output logic       HALTED,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_OPERAND   = 3'd2,
    S_BRANCH    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_HALT      = 3'd5,
    S_UNUSED6   = 3'd6,
    S_UNUSED7   = 3'd7
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] ir_reg;
  logic [7:0] ir_nxt;
  logic [7:0] baddr_reg;
  logic [7:0] baddr_nxt;
  logic       pc_count_dec;
  logic       branch_dec;
  logic       exec_dec;
  logic       halted_dec;

  // Two-byte instructions are the jumps; they take the OPERAND path.
  function automatic logic is_jump(input logic [3:0] opc);
    return (opc == OP_JMP) || (opc == OP_JZ) || (opc == OP_JC);
  endfunction

  // Branch condition is evaluated against the flags present during the BRANCH_ST strobe cycle.
  function automatic logic branch_taken(input logic [3:0] opc, input logic zf, input logic cf);
    return (opc == OP_JMP) || ((opc == OP_JZ) && zf) || ((opc == OP_JC) && cf);
  endfunction

  // State, instruction and branch-address registers advance only on strobe edges.
  always_ff @(posedge CLK or posedge ACLR) begin
    if (ACLR) begin
      state     <= S_FETCH;
      ir_reg    <= 8'h00;
      baddr_reg <= 8'h00;
    end else if (SLOW_CLOCK_STRB) begin
      state     <= state_nxt;
      ir_reg    <= ir_nxt;
      baddr_reg <= baddr_nxt;
    end
  end

  // Next-state logic and per-state request decode (before gating with the strobe).
  always_comb begin
    state_nxt    = state;
    ir_nxt       = ir_reg;
    baddr_nxt    = baddr_reg;
    pc_count_dec = 1'b0;
    branch_dec   = 1'b0;
    exec_dec     = 1'b0;
    halted_dec   = 1'b0;
    case (state)
      S_FETCH: begin
        pc_count_dec = 1'b1;
        ir_nxt       = MEM_DATA;
        state_nxt    = S_DECODE;
      end
      S_DECODE: begin
        if (ir_reg[7:4] == OP_HLT) begin
          state_nxt = S_HALT;
        end else if (is_jump(ir_reg[7:4])) begin
          state_nxt = S_OPERAND;
        end else begin
          state_nxt = S_EXECUTE;
        end
      end
      S_OPERAND: begin
        // Counting here steps the PC past the address byte, so a not-taken jump
        // falls through to the instruction after it.
        pc_count_dec = 1'b1;
        baddr_nxt    = MEM_DATA;
        state_nxt    = S_BRANCH;
      end
      S_BRANCH: begin
        branch_dec = branch_taken(ir_reg[7:4], ZERO_FLAG, CARRY_FLAG);
        state_nxt  = S_FETCH;
      end
      S_EXECUTE: begin
        exec_dec  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        halted_dec = 1'b1;
        state_nxt  = S_HALT;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // PC requests and the execute strobe are single-CLK pulses aligned with the PC's strobe edge.
  // Only one PC request is decoded per state, so count and branch can never coincide.
  always_comb begin
    PC_COUNT       = pc_count_dec & SLOW_CLOCK_STRB;
    BRANCH         = branch_dec & SLOW_CLOCK_STRB;
    EXEC_STRB      = exec_dec & SLOW_CLOCK_STRB;
    HALTED         = halted_dec;
    BRANCH_ADDRESS = baddr_reg;
    IR             = ir_reg;
    STATE          = state;
  end

endmodule

// File: tb/tb_sap_fetch_sequencer.sv
// Bench for sap_fetch_sequencer: models program memory and the program counter. It pushes
// the expected per-strobe outputs onto a scoreboard and compares them on each strobe cycle.
module tb_sap_fetch_sequencer;

  logic       CLK;
  logic       ACLR;
  logic       SLOW_CLOCK_STRB;
  logic [7:0] MEM_DATA;
  logic       ZERO_FLAG;
  logic       CARRY_FLAG;
  logic       PC_COUNT;
  logic       BRANCH;
  logic [7:0] BRANCH_ADDRESS;
  logic [7:0] IR;
  logic       EXEC_STRB;
  logic       HALTED;
  logic [2:0] STATE;

  logic [7:0] mem [256];
  logic [7:0] pc;
  logic       pc_ld;
  logic [7:0] pc_ld_val;

  int total;
  int bad;

  typedef struct {
    logic [2:0] st;
    logic       pcc;
    logic       br;
    logic       ex;
    logic       hl;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] ba;
  } exp_t;

  exp_t sb[$];

  sap_fetch_sequencer dut (
    .CLK            (CLK),
    .ACLR           (ACLR),
    .SLOW_CLOCK_STRB(SLOW_CLOCK_STRB),
    .MEM_DATA       (MEM_DATA),
    .ZERO_FLAG      (ZERO_FLAG),
    .CARRY_FLAG     (CARRY_FLAG),
    .PC_COUNT       (PC_COUNT),
    .BRANCH         (BRANCH),
    .BRANCH_ADDRESS (BRANCH_ADDRESS),
    .IR             (IR),
    .EXEC_STRB      (EXEC_STRB),
    .HALTED         (HALTED),
    .STATE          (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign MEM_DATA = mem[pc];

  // Program counter model: load, branch or increment on strobe edges.
  always @(posedge CLK) begin
    if (pc_ld) pc <= pc_ld_val;
    else if (SLOW_CLOCK_STRB) begin
      if (BRANCH) pc <= BRANCH_ADDRESS;
      else if (PC_COUNT) pc <= pc + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic pcc, input logic br, input logic ex,
                      input logic hl, input logic [7:0] p, input logic [7:0] ir_v,
                      input logic [7:0] ba);
    exp_t e;
    e.st = st; e.pcc = pcc; e.br = br; e.ex = ex; e.hl = hl;
    e.pc = p; e.ir = ir_v; e.ba = ba;
    sb.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic start(input logic [7:0] pc0);
    ACLR = 1'b1;
    SLOW_CLOCK_STRB = 1'b0;
    @(negedge CLK);
    pc_ld = 1'b1;
    pc_ld_val = pc0;
    @(negedge CLK);
    pc_ld = 1'b0;
    ACLR = 1'b0;
    @(negedge CLK);
  endtask

  // One strobe cycle followed by three idle cycles; flags are inverted while idle.
  task automatic do_strobe(input logic zf, input logic cf);
    exp_t e;
    @(negedge CLK);
    SLOW_CLOCK_STRB = 1'b1;
    ZERO_FLAG = zf;
    CARRY_FLAG = cf;
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("state", {29'd0, STATE}, {29'd0, e.st});
      chk("pc_count", {31'd0, PC_COUNT}, {31'd0, e.pcc});
      chk("branch", {31'd0, BRANCH}, {31'd0, e.br});
      chk("exec_strb", {31'd0, EXEC_STRB}, {31'd0, e.ex});
      chk("halted", {31'd0, HALTED}, {31'd0, e.hl});
      chk("fetch_pc", {24'd0, pc}, {24'd0, e.pc});
      chk("ir", {24'd0, IR}, {24'd0, e.ir});
      chk("branch_addr", {24'd0, BRANCH_ADDRESS}, {24'd0, e.ba});
      chk("count_branch_excl", {31'd0, PC_COUNT & BRANCH}, 32'd0);
    end
    @(negedge CLK);
    SLOW_CLOCK_STRB = 1'b0;
    ZERO_FLAG = ~zf;
    CARRY_FLAG = ~cf;
    #1;
    chk("idle_pulses", {29'd0, PC_COUNT, BRANCH, EXEC_STRB}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("idle_pulses_late", {29'd0, PC_COUNT, BRANCH, EXEC_STRB}, 32'd0);
    if (sb.size() != 0) chk("idle_state", {29'd0, STATE}, {29'd0, sb[0].st});
  endtask

  // Conditional jump at 00 with target 80; the unrelated flag is held high at the decision.
  task automatic cond_case(input logic [7:0] opc, input logic is_c, input logic taken);
    clear_mem();
    mem[8'h00] = opc;
    mem[8'h01] = 8'h80;
    mem[8'h02] = 8'h3B;
    mem[8'h80] = 8'h2A;
    start(8'h00);
    push(3'd0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    push(3'd1, 0, 0, 0, 0, 8'h01, opc, 8'h00);
    push(3'd2, 1, 0, 0, 0, 8'h01, opc, 8'h00);
    push(3'd3, 0, taken, 0, 0, 8'h02, opc, 8'h80);
    push(3'd0, 1, 0, 0, 0, taken ? 8'h80 : 8'h02, opc, 8'h80);
    push(3'd1, 0, 0, 0, 0, taken ? 8'h81 : 8'h03, taken ? 8'h2A : 8'h3B, 8'h80);
    for (int i = 0; i < 3; i++) do_strobe(~taken, ~taken);
    if (is_c) do_strobe(1'b1, taken);
    else do_strobe(taken, 1'b1);
    for (int i = 0; i < 2; i++) do_strobe(~taken, ~taken);
  endtask

  initial begin
    total = 0;
    bad = 0;
    ACLR = 1'b1;
    SLOW_CLOCK_STRB = 1'b0;
    ZERO_FLAG = 1'b0;
    CARRY_FLAG = 1'b0;
    pc_ld = 1'b0;
    pc_ld_val = 8'h00;
    pc = 8'h00;
    clear_mem();
    #2;
    chk("rst_state", {29'd0, STATE}, 32'd0);
    chk("rst_ir", {24'd0, IR}, 32'd0);
    chk("rst_baddr", {24'd0, BRANCH_ADDRESS}, 32'd0);
    chk("rst_halted", {31'd0, HALTED}, 32'd0);

    // Straight-line: two non-branch instructions.
    clear_mem();
    mem[8'h00] = 8'h15;
    mem[8'h01] = 8'h23;
    start(8'h00);
    push(3'd0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    push(3'd1, 0, 0, 0, 0, 8'h01, 8'h15, 8'h00);
    push(3'd4, 0, 0, 1, 0, 8'h01, 8'h15, 8'h00);
    push(3'd0, 1, 0, 0, 0, 8'h01, 8'h15, 8'h00);
    push(3'd1, 0, 0, 0, 0, 8'h02, 8'h23, 8'h00);
    push(3'd4, 0, 0, 1, 0, 8'h02, 8'h23, 8'h00);
    for (int i = 0; i < 6; i++) do_strobe(1'b0, 1'b0);

    // JMP to 40, then the jump found there is interrupted by reset mid-OPERAND.
    clear_mem();
    mem[8'h00] = 8'h60;
    mem[8'h01] = 8'h40;
    mem[8'h40] = 8'h70;
    mem[8'h41] = 8'h33;
    start(8'h00);
    push(3'd0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    push(3'd1, 0, 0, 0, 0, 8'h01, 8'h60, 8'h00);
    push(3'd2, 1, 0, 0, 0, 8'h01, 8'h60, 8'h00);
    push(3'd3, 0, 1, 0, 0, 8'h02, 8'h60, 8'h40);
    push(3'd0, 1, 0, 0, 0, 8'h40, 8'h60, 8'h40);
    push(3'd1, 0, 0, 0, 0, 8'h41, 8'h70, 8'h40);
    for (int i = 0; i < 6; i++) do_strobe(1'b0, 1'b0);
    chk("pre_rst_state", {29'd0, STATE}, 32'd2);
    chk("pre_rst_baddr", {24'd0, BRANCH_ADDRESS}, 32'h40);
    @(negedge CLK);
    #2 ACLR = 1'b1;
    #1;
    chk("mid_rst_state", {29'd0, STATE}, 32'd0);
    chk("mid_rst_ir", {24'd0, IR}, 32'd0);
    chk("mid_rst_baddr", {24'd0, BRANCH_ADDRESS}, 32'd0);
    chk("mid_rst_halted", {31'd0, HALTED}, 32'd0);
    @(negedge CLK);
    ACLR = 1'b0;
    push(3'd0, 1, 0, 0, 0, 8'h41, 8'h00, 8'h00);
    do_strobe(1'b0, 1'b0);

    // Conditional jumps, not taken and taken, on both flags.
    cond_case(8'h70, 1'b0, 1'b0);
    cond_case(8'h70, 1'b0, 1'b1);
    cond_case(8'h80, 1'b1, 1'b0);
    cond_case(8'h80, 1'b1, 1'b1);

    // Halt: reached after two strobes, then inert until reset.
    clear_mem();
    mem[8'h00] = 8'hF0;
    start(8'h00);
    push(3'd0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    push(3'd1, 0, 0, 0, 0, 8'h01, 8'hF0, 8'h00);
    for (int i = 0; i < 20; i++) push(3'd5, 0, 0, 0, 1, 8'h01, 8'hF0, 8'h00);
    for (int i = 0; i < 22; i++) do_strobe(i[0], ~i[0]);
    chk("halt_held", {31'd0, HALTED}, 32'd1);
    @(negedge CLK);
    #2 ACLR = 1'b1;
    #1;
    chk("halt_cleared", {31'd0, HALTED}, 32'd0);
    chk("halt_rst_state", {29'd0, STATE}, 32'd0);
    @(negedge CLK);
    ACLR = 1'b0;

    // Wrap: jump at 20 to FF; the jump at FF takes its operand from 00.
    clear_mem();
    mem[8'h20] = 8'h60;
    mem[8'h21] = 8'hFF;
    mem[8'hFF] = 8'h60;
    mem[8'h00] = 8'h10;
    start(8'h20);
    push(3'd0, 1, 0, 0, 0, 8'h20, 8'h00, 8'h00);
    push(3'd1, 0, 0, 0, 0, 8'h21, 8'h60, 8'h00);
    push(3'd2, 1, 0, 0, 0, 8'h21, 8'h60, 8'h00);
    push(3'd3, 0, 1, 0, 0, 8'h22, 8'h60, 8'hFF);
    push(3'd0, 1, 0, 0, 0, 8'hFF, 8'h60, 8'hFF);
    push(3'd1, 0, 0, 0, 0, 8'h00, 8'h60, 8'hFF);
    push(3'd2, 1, 0, 0, 0, 8'h00, 8'h60, 8'hFF);
    push(3'd3, 0, 1, 0, 0, 8'h01, 8'h60, 8'h10);
    push(3'd0, 1, 0, 0, 0, 8'h10, 8'h60, 8'h10);
    for (int i = 0; i < 9; i++) do_strobe(1'b0, 1'b0);

    chk("sb_left", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap_fetch_sequencer.md
Name: sap_fetch_sequencer

Overview:
- Control-side counterpart of the program counter.
- Fetches instruction bytes from program memory at the current PC value and decodes the opcode.
- Drives the PC's PC_COUNT, BRANCH and BRANCH_ADDRESS inputs, and issues one execute strobe per non-branch instruction to the datapath.
- Advances only on SLOW_CLOCK_STRB cycles, in lock-step with the PC.

Parameters:
- OP_JMP, 4'h6, opcode of unconditional jump (two-byte instruction)
- OP_JZ, 4'h7, opcode of jump-if-zero (two-byte)
- OP_JC, 4'h8, opcode of jump-if-carry (two-byte)
- OP_HLT, 4'hF, opcode of halt

Ports:
- CLK  in  1  system clock; all state changes on posedge
- ACLR  in  1  asynchronous reset, active-high
- SLOW_CLOCK_STRB  in  1  one-CLK advance strobe shared with the PC
- MEM_DATA  in  8  program memory byte at address PC_VAL (combinational read)
- ZERO_FLAG  in  1  ALU zero flag
- CARRY_FLAG  in  1  ALU carry flag
- PC_COUNT  out  1  PC increment request
- BRANCH  out  1  PC load request
- BRANCH_ADDRESS  out  8  PC load value
- IR  out  8  instruction register
- EXEC_STRB  out  1  one-CLK execute pulse to datapath; the datapath decodes IR[7:4]/IR[3:0]
- HALTED  out  1  high while in HALT
- STATE  out  3  encoded state, for debug

Behaviour:
- Reset: ACLR=1 forces state FETCH, IR=8'h00, branch address register=8'h00, HALTED=0. Takes effect immediately, independent of CLK/strobe, including mid-instruction.
- Advance rule: state, IR and address register update only on posedge CLK with SLOW_CLOCK_STRB=1. With strobe low, everything holds.
- PC_COUNT, BRANCH and EXEC_STRB are combinational decodes of state, ANDed with SLOW_CLOCK_STRB. They are therefore single-CLK pulses coincident with the edge on which the PC acts.
- PC_COUNT and BRANCH are never high together.
- BRANCH_ADDRESS always equals the branch address register.
- States:
  - FETCH (0): PC_COUNT=1. On strobe: IR<=MEM_DATA, go to DECODE.
  - DECODE (1): on strobe:
    - IR[7:4]==OP_HLT -> HALT
    - IR[7:4] in {OP_JMP, OP_JZ, OP_JC} -> OPERAND
    - else -> EXECUTE
  - OPERAND (2): PC_COUNT=1, skipping the address byte. On strobe: address register<=MEM_DATA, go to BRANCH_ST.
  - BRANCH_ST (3): condition true for JMP, for JZ&&ZERO_FLAG, for JC&&CARRY_FLAG. Flags are sampled this cycle. If true, BRANCH=1. On strobe -> FETCH.
  - EXECUTE (4): EXEC_STRB=1. On strobe -> FETCH.
  - HALT (5): HALTED=1. No PC_COUNT, BRANCH or EXEC_STRB. Leaves only via ACLR.
  - Codes 6-7 are unreachable and recover to FETCH on the next strobe.
- Timing per instruction, in strobes:
  - Non-branch: 3 (FETCH, DECODE, EXECUTE).
  - Jump: 4. PC ends at the target if taken, otherwise at the jump instruction address+2.
  - Halt: 2 to reach HALT; HALTED rises on the second strobe edge.
- Wrap-around: the PC wraps naturally (8'hFF+1=8'h00). The sequencer adds no special handling, and an operand byte at 8'h00 after an instruction at 8'hFF is legal.
- Flag changes outside the BRANCH_ST strobe cycle have no effect.

Test Plan:
- Reset: ACLR pulse mid-OPERAND -> STATE=0, IR=00, BRANCH_ADDRESS=00, HALTED=0 immediately. First strobe after release gives PC_COUNT=1.
- Straight-line: memory 00:8'h15, 01:8'h23, strobe every 4 CLKs -> IR=15 then EXEC_STRB one CLK wide, then IR=23. Exactly one PC_COUNT per instruction. Nothing changes between strobes.
- JMP: 00:8'h60, 01:8'h40 -> PC_COUNT twice, then BRANCH=1 with BRANCH_ADDRESS=40. Next fetch reads address 40. EXEC_STRB never asserted.
- Conditional: 00:8'h70, 01:8'h80 with ZERO_FLAG=0 -> no BRANCH, next fetch at 02. Repeat with ZERO_FLAG=1 -> BRANCH, next fetch at 80. Same pair for JC/CARRY_FLAG.
- Halt: 00:8'hF0 -> HALTED=1 after 2 strobes. 20 further strobes produce no PC_COUNT, BRANCH or EXEC_STRB. ACLR clears HALTED.
- Wrap: JMP to FF, where FF holds 8'h60 and 00 holds 8'h10 -> operand read from 00, branch to 10.
